display_capture: RTL

Receive-side counterpart of the 8-digit multiplexed seven-segment scanner. Watches the scanner's digit select and segment bus, waits for each digit to settle, and decodes the lit pattern back to a hex nibble. Reassembles the 32-bit value the scanner is showing. Used for loopback self-check of the display path and as a bench-side monitor.

---
 rtl/display_pkg.sv | 47 ++++
 rtl/display_capture_if.sv | 20 ++
 rtl/display_capture_seg7_decode.sv | 39 +++
 rtl/display_capture.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path: glyph table, segment
// bit positions and the capture-side FSM state encoding.
package display_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
    GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
  };

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic [1:0] {
    ST_WAIT       = 2'd0,
    ST_SETTLE_CNT = 2'd1,
    ST_HELD       = 2'd2
  } cap_state_e;

  // Encoder side of the table, used by the scanner.
  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/display_capture_if.sv
// Scanner-to-capture bus: digit select and active-low segments in, captured
// frame and status pulses out.
interface display_capture_if;
  logic [2:0]  which;
  logic [7:0]  seg;
  logic [32:1] data;
  logic        valid;
  logic        bad_digit;
  logic        frame_drop;

  modport master (
    output which, seg,
    input  data, valid, bad_digit, frame_drop
  );

  modport slave (
    input  which, seg,
    output data, valid, bad_digit, frame_drop
  );
endinterface

// File: rtl/display_capture_seg7_decode.sv
// Combinational seven-segment decoder: active-low g..a pattern to hex nibble,
// with ok low for any pattern that is not one of the sixteen glyphs.
module seg7_decode
  import display_pkg::*;
(
  input  logic [6:0] seg,
  output logic       ok,
  output logic [3:0] nibble
);

  // Pattern match against the shared glyph table.
  always_comb begin
    ok     = 1'b1;
    nibble = 4'h0;
    case (seg)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: begin
        ok     = 1'b0;
        nibble = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/display_capture.sv
// Receive side of the multiplexed seven-segment scanner: debounces each digit,
// decodes it and reassembles the 32-bit value being displayed.
module display_capture
  import display_pkg::*;
#(
  parameter int SETTLE = 4
)
(
  input logic              clk,
  input logic              rst,
  display_capture_if.slave bus
);

  localparam int CW = $clog2(SETTLE + 1);

  logic [9:0]       cur_s;
  logic [2:0]       cur_which_s;
  logic [9:0]       sample_r;
  logic             change_s;

  cap_state_e       state_r;
  cap_state_e       state_nx_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nx_s;
  logic             accept_s;

  logic             dec_ok_s;
  logic [3:0]       dec_nib_s;

  logic [7:0][3:0]  shadow_r;
  logic [7:0][3:0]  shadow_nx_s;
  logic [7:0]       got_r;
  logic [7:0]       got_nx_s;
  logic             tainted_r;
  logic             tainted_nx_s;
  logic             close_s;
  logic             frame_ok_s;

  logic [32:1]      data_r;
  logic             valid_r;
  logic             bad_digit_r;
  logic             frame_drop_r;

  // dp is deliberately left out of the sample so it never counts as a change.
  assign cur_s       = {bus.which, bus.seg[SEG_G:SEG_A]};
  assign cur_which_s = bus.which;
  assign change_s    = (cur_s != sample_r);

  seg7_decode u_decode (
    .seg    (bus.seg[SEG_G:SEG_A]),
    .ok     (dec_ok_s),
    .nibble (dec_nib_s)
  );

  // Settle FSM: next state, next counter and the acceptance strobe.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    accept_s   = 1'b0;
    case (state_r)
      ST_WAIT: begin
        state_nx_s = ST_SETTLE_CNT;
        cnt_nx_s   = CW'(1);
      end
      ST_SETTLE_CNT: begin
        if (change_s) begin
          cnt_nx_s = CW'(1);
        end else if (cnt_r >= CW'(SETTLE - 1)) begin
          accept_s   = 1'b1;
          state_nx_s = ST_HELD;
          cnt_nx_s   = CW'(SETTLE);
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      ST_HELD: begin
        if (change_s) begin
          state_nx_s = ST_SETTLE_CNT;
          cnt_nx_s   = CW'(1);
        end else begin
          state_nx_s = ST_HELD;
        end
      end
      default: begin
        state_nx_s = ST_WAIT;
        cnt_nx_s   = '0;
      end
    endcase
  end

  // Frame bookkeeping for the digit being accepted this cycle.
  always_comb begin
    shadow_nx_s  = shadow_r;
    got_nx_s     = got_r;
    tainted_nx_s = tainted_r;
    if (accept_s && dec_ok_s) begin
      shadow_nx_s[cur_which_s] = dec_nib_s;
      got_nx_s[cur_which_s]    = 1'b1;
    end else if (accept_s) begin
      tainted_nx_s = 1'b1;
    end else begin
      tainted_nx_s = tainted_r;
    end
  end

  assign close_s    = accept_s && (cur_which_s == 3'd7);
  assign frame_ok_s = (got_nx_s == 8'hFF) && !tainted_nx_s;

  // FSM state and settle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_WAIT;
      cnt_r    <= '0;
      sample_r <= '0;
    end else begin
      state_r  <= state_nx_s;
      cnt_r    <= cnt_nx_s;
      sample_r <= cur_s;
    end
  end

  // Shadow nibbles plus per-frame got/tainted tracking; both clear on close.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r  <= '0;
      got_r     <= 8'h00;
      tainted_r <= 1'b0;
    end else begin
      shadow_r <= shadow_nx_s;
      if (close_s) begin
        got_r     <= 8'h00;
        tainted_r <= 1'b0;
      end else begin
        got_r     <= got_nx_s;
        tainted_r <= tainted_nx_s;
      end
    end
  end

  // Registered frame output and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r       <= '0;
      valid_r      <= 1'b0;
      bad_digit_r  <= 1'b0;
      frame_drop_r <= 1'b0;
    end else begin
      if (close_s && frame_ok_s) begin
        data_r <= shadow_nx_s;
      end else begin
        data_r <= data_r;
      end
      valid_r      <= close_s && frame_ok_s;
      bad_digit_r  <= accept_s && !dec_ok_s;
      frame_drop_r <= close_s && !frame_ok_s;
    end
  end

  assign bus.data       = data_r;
  assign bus.valid      = valid_r;
  assign bus.bad_digit  = bad_digit_r;
  assign bus.frame_drop = frame_drop_r;

endmodule
